// File: rtl/axi_rd_arbiter_2to1.sv
// Two-requester AXI4 read arbiter: round-robin AR grant, one burst forwarded at a time,
// read data routed back to the issuing requester through an in-order owner FIFO.
module axi_rd_arbiter_2to1 #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 128,
  parameter int unsigned MAX_OUTSTANDING    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  // requester 0
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [7:0]                    s0_axi_arlen,
  input  logic [2:0]                    s0_axi_arsize,
  input  logic [1:0]                    s0_axi_arburst,
  input  logic                          s0_axi_arvalid,
  output logic                          s0_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]                    s0_axi_rresp,
  output logic                          s0_axi_rlast,
  output logic                          s0_axi_rvalid,
  input  logic                          s0_axi_rready,
  // requester 1
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [7:0]                    s1_axi_arlen,
  input  logic [2:0]                    s1_axi_arsize,
  input  logic [1:0]                    s1_axi_arburst,
  input  logic                          s1_axi_arvalid,
  output logic                          s1_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]                    s1_axi_rresp,
  output logic                          s1_axi_rlast,
  output logic                          s1_axi_rvalid,
  input  logic                          s1_axi_rready,
  // shared slave
  output logic                          M_axi_arid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] M_axi_araddr,
  output logic [7:0]                    M_axi_arlen,
  output logic [2:0]                    M_axi_arsize,
  output logic [1:0]                    M_axi_arburst,
  output logic                          M_axi_arlock,
  output logic [3:0]                    M_axi_arcache,
  output logic [2:0]                    M_axi_arprot,
  output logic [3:0]                    M_axi_arqos,
  output logic                          M_axi_arvalid,
  input  logic                          M_axi_arready,
  input  logic                          M_axi_rid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] M_axi_rdata,
  input  logic [1:0]                    M_axi_rresp,
  input  logic                          M_axi_rlast,
  input  logic                          M_axi_rvalid,
  output logic                          M_axi_rready
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StAddr} state_e;

  state_e state_q, state_d;

  logic                          rr_last_q, rr_last_d;
  logic                          owner_q, owner_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                    arlen_q, arlen_d;
  logic [2:0]                    arsize_q, arsize_d;
  logic [1:0]                    arburst_q, arburst_d;

  logic [MAX_OUTSTANDING-1:0]    fifo_q;
  logic [PtrW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]               count_q;

  logic eligible, winner, grant, push, pop, fifo_empty, head;

  // Single ID, in-order slave: the returned ID carries no information.
  logic unused_rid;
  assign unused_rid = M_axi_rid;

  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Gated by reset_n so no requester sees a grant while reset is held.
  assign eligible = reset_n && (state_q == StIdle) && (count_q < CntW'(MAX_OUTSTANDING));

  always_comb begin
    winner = 1'b0;
    if (s0_axi_arvalid && s1_axi_arvalid) begin
      winner = ~rr_last_q;
    end else begin
      winner = s1_axi_arvalid;
    end
  end

  assign grant = eligible && (s0_axi_arvalid || s1_axi_arvalid);
  assign push  = (state_q == StAddr) && M_axi_arready;
  assign pop   = M_axi_rvalid && M_axi_rready && M_axi_rlast;

  // AR FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

  // AR FSM: next state and capture of the granted request
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d   = StAddr;
          owner_d   = winner;
          rr_last_d = winner;
          araddr_d  = winner ? s1_axi_araddr  : s0_axi_araddr;
          arlen_d   = winner ? s1_axi_arlen   : s0_axi_arlen;
          arsize_d  = winner ? s1_axi_arsize  : s0_axi_arsize;
          arburst_d = winner ? s1_axi_arburst : s0_axi_arburst;
        end
      end
      StAddr: begin
        if (M_axi_arready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // AR FSM: outputs
  always_comb begin
    M_axi_arvalid  = 1'b0;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    unique case (state_q)
      StIdle: begin
        s0_axi_arready = eligible && s0_axi_arvalid && !winner;
        s1_axi_arready = eligible && s1_axi_arvalid && winner;
      end
      StAddr: M_axi_arvalid = 1'b1;
      default: M_axi_arvalid = 1'b0;
    endcase
  end

  // Owner FIFO: one entry per burst accepted by the slave, retired on its last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= owner_q;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign M_axi_arid    = 1'b0;
  assign M_axi_araddr  = araddr_q;
  assign M_axi_arlen   = arlen_q;
  assign M_axi_arsize  = arsize_q;
  assign M_axi_arburst = arburst_q;
  assign M_axi_arlock  = 1'b0;
  assign M_axi_arcache = 4'b0011;
  assign M_axi_arprot  = 3'b000;
  assign M_axi_arqos   = 4'b0000;

  // R path: payload fans out to both requesters, only valid/ready follow the FIFO head.
  assign M_axi_rready  = !fifo_empty && (head ? s1_axi_rready : s0_axi_rready);
  assign s0_axi_rvalid = M_axi_rvalid && !fifo_empty && !head;
  assign s1_axi_rvalid = M_axi_rvalid && !fifo_empty && head;

  assign s0_axi_rdata  = M_axi_rdata;
  assign s0_axi_rresp  = M_axi_rresp;
  assign s0_axi_rlast  = M_axi_rlast;
  assign s1_axi_rdata  = M_axi_rdata;
  assign s1_axi_rresp  = M_axi_rresp;
  assign s1_axi_rlast  = M_axi_rlast;

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Bench for axi_rd_arbiter_2to1: queue-based arbitration/routing model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_axi_rd_arbiter_2to1;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [AW-1:0] s0_axi_araddr, s1_axi_araddr, M_axi_araddr;
  logic [7:0]    s0_axi_arlen, s1_axi_arlen, M_axi_arlen;
  logic [2:0]    s0_axi_arsize, s1_axi_arsize, M_axi_arsize, M_axi_arprot;
  logic [1:0]    s0_axi_arburst, s1_axi_arburst, M_axi_arburst;
  logic          s0_axi_arvalid, s0_axi_arready, s1_axi_arvalid, s1_axi_arready;
  logic [DW-1:0] s0_axi_rdata, s1_axi_rdata, M_axi_rdata;
  logic [1:0]    s0_axi_rresp, s1_axi_rresp, M_axi_rresp;
  logic          s0_axi_rlast, s0_axi_rvalid, s0_axi_rready;
  logic          s1_axi_rlast, s1_axi_rvalid, s1_axi_rready;
  logic          M_axi_arid, M_axi_arlock, M_axi_arvalid, M_axi_arready;
  logic [3:0]    M_axi_arcache, M_axi_arqos;
  logic          M_axi_rid, M_axi_rlast, M_axi_rvalid, M_axi_rready;

  axi_rd_arbiter_2to1 #(
    .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen), .s0_axi_arsize(s0_axi_arsize),
    .s0_axi_arburst(s0_axi_arburst), .s0_axi_arvalid(s0_axi_arvalid),
    .s0_axi_arready(s0_axi_arready), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen), .s1_axi_arsize(s1_axi_arsize),
    .s1_axi_arburst(s1_axi_arburst), .s1_axi_arvalid(s1_axi_arvalid),
    .s1_axi_arready(s1_axi_arready), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .M_axi_arid(M_axi_arid), .M_axi_araddr(M_axi_araddr), .M_axi_arlen(M_axi_arlen),
    .M_axi_arsize(M_axi_arsize), .M_axi_arburst(M_axi_arburst), .M_axi_arlock(M_axi_arlock),
    .M_axi_arcache(M_axi_arcache), .M_axi_arprot(M_axi_arprot), .M_axi_arqos(M_axi_arqos),
    .M_axi_arvalid(M_axi_arvalid), .M_axi_arready(M_axi_arready), .M_axi_rid(M_axi_rid),
    .M_axi_rdata(M_axi_rdata), .M_axi_rresp(M_axi_rresp), .M_axi_rlast(M_axi_rlast),
    .M_axi_rvalid(M_axi_rvalid), .M_axi_rready(M_axi_rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // requester stimulus queues and handshake flags
  logic [AW-1:0] rq_addr0[$], rq_addr1[$];
  logic [7:0]    rq_len0[$], rq_len1[$];
  bit hs0 = 0, hs1 = 0, rr0 = 1, rr1 = 1;

  // slave behaviour
  bit slv_arready = 1, slv_stall = 0, stray = 0;
  logic [AW-1:0] slv_addr[$];
  logic [7:0]    slv_len[$];
  int slv_beat = 0;

  // reference model
  bit m_busy = 0, m_own = 0, m_last = 1;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;
  logic [2:0]    m_size;
  logic [1:0]    m_burst;
  bit m_q[$];
  logic [DW-1:0] exp_d0[$], exp_d1[$];
  bit exp_l0[$], exp_l1[$];

  // event logs
  int rx0 = 0, rx1 = 0, stall_cnt = 0;
  int gl[$], gl_cyc[$], mhs_cyc[$], pop_cyc[$];

  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a, input int b);
    logic [31:0] bb;
    bb = b;
    return {a, ~a, a ^ 32'h5A5A_0000, bb};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit idle();
    return rq_addr0.size() == 0 && rq_addr1.size() == 0 && slv_addr.size() == 0 &&
           exp_d0.size() == 0 && exp_d1.size() == 0 && !m_busy && m_q.size() == 0;
  endfunction

  task automatic drive();
    logic [AW-1:0] da;
    logic [7:0] dl;
    if (hs0) begin da = rq_addr0.pop_front(); dl = rq_len0.pop_front(); hs0 = 0; end
    if (hs1) begin da = rq_addr1.pop_front(); dl = rq_len1.pop_front(); hs1 = 0; end
    if (rq_addr0.size() > 0) begin
      s0_axi_arvalid = 1; s0_axi_araddr = rq_addr0[0]; s0_axi_arlen = rq_len0[0];
    end else begin
      s0_axi_arvalid = 0; s0_axi_araddr = '0; s0_axi_arlen = '0;
    end
    if (rq_addr1.size() > 0) begin
      s1_axi_arvalid = 1; s1_axi_araddr = rq_addr1[0]; s1_axi_arlen = rq_len1[0];
    end else begin
      s1_axi_arvalid = 0; s1_axi_araddr = '0; s1_axi_arlen = '0;
    end
    s0_axi_arsize = 3'd4; s0_axi_arburst = 2'b01;
    s1_axi_arsize = 3'd3; s1_axi_arburst = 2'b01;
    s0_axi_rready = rr0;  s1_axi_rready = rr1;
    M_axi_arready = slv_arready;
    M_axi_rid = 1'b0;
    if (slv_addr.size() > 0 && !slv_stall) begin
      M_axi_rvalid = 1; M_axi_rdata = mkdata(slv_addr[0], slv_beat);
      M_axi_rresp = 2'(slv_beat); M_axi_rlast = (slv_beat == int'(slv_len[0]));
    end else if (stray) begin
      M_axi_rvalid = 1; M_axi_rdata = {4{32'hDEAD_BEEF}}; M_axi_rresp = 2'b10; M_axi_rlast = 1;
    end else begin
      M_axi_rvalid = 0; M_axi_rdata = '0; M_axi_rresp = '0; M_axi_rlast = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!idle() && n < budget) begin step(); n++; end
    chk("drain_in_budget", idle(), 1);
  endtask

  // Model check and update, once per cycle away from the active edge.
  always @(negedge clk) begin
    bit pick, gnt, any, erdy, head, nonempty;
    cyc++;
    if (!reset_n) begin
      m_busy = 0; m_last = 1; m_own = 0; m_q.delete();
      m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
      chk("rst_m_arvalid", M_axi_arvalid, 0);
      chk("rst_m_rready", M_axi_rready, 0);
      chk("rst_arready", {s0_axi_arready, s1_axi_arready}, 0);
      chk("rst_rvalid", {s0_axi_rvalid, s1_axi_rvalid}, 0);
      chk("rst_m_ar_regs", {M_axi_araddr, M_axi_arlen, M_axi_arsize, M_axi_arburst}, 0);
    end else begin
      nonempty = m_q.size() > 0;
      head = 0;
      if (nonempty) head = m_q[0];
      any  = s0_axi_arvalid || s1_axi_arvalid;
      pick = (s0_axi_arvalid && s1_axi_arvalid) ? !m_last : s1_axi_arvalid;
      gnt  = any && !m_busy && (m_q.size() < MAXO);
      erdy = nonempty && (head ? s1_axi_rready : s0_axi_rready);

      chk("s0_arready", s0_axi_arready, gnt && !pick);
      chk("s1_arready", s1_axi_arready, gnt && pick);
      chk("m_arvalid", M_axi_arvalid, m_busy);
      chk("m_ar_fields", {M_axi_araddr, M_axi_arlen, M_axi_arsize, M_axi_arburst},
          {m_addr, m_len, m_size, m_burst});
      chk("m_ar_const", {M_axi_arid, M_axi_arlock, M_axi_arcache, M_axi_arprot, M_axi_arqos},
          {1'b0, 1'b0, 4'b0011, 3'b000, 4'b0000});
      chk("m_rready", M_axi_rready, erdy);
      chk("s0_rvalid", s0_axi_rvalid, M_axi_rvalid && nonempty && !head);
      chk("s1_rvalid", s1_axi_rvalid, M_axi_rvalid && nonempty && head);
      chk("s0_rdata_pass", s0_axi_rdata, M_axi_rdata);
      chk("s1_rdata_pass", s1_axi_rdata, M_axi_rdata);
      chk("r_side_pass", {s0_axi_rresp, s0_axi_rlast, s1_axi_rresp, s1_axi_rlast},
          {M_axi_rresp, M_axi_rlast, M_axi_rresp, M_axi_rlast});

      // per-requester beat scoreboard
      if (s0_axi_rvalid && s0_axi_rready) begin
        rx0++;
        chk("s0_beat_pending", exp_d0.size() > 0, 1);
        if (exp_d0.size() > 0) begin
          chk("s0_beat_data", s0_axi_rdata, exp_d0.pop_front());
          chk("s0_beat_last", s0_axi_rlast, exp_l0.pop_front());
        end
      end
      if (s1_axi_rvalid && s1_axi_rready) begin
        rx1++;
        chk("s1_beat_pending", exp_d1.size() > 0, 1);
        if (exp_d1.size() > 0) begin
          chk("s1_beat_data", s1_axi_rdata, exp_d1.pop_front());
          chk("s1_beat_last", s1_axi_rlast, exp_l1.pop_front());
        end
      end

      // observed handshakes drive the stimulus side
      if (s0_axi_arvalid && s0_axi_arready) begin hs0 = 1; gl.push_back(0); gl_cyc.push_back(cyc); end
      if (s1_axi_arvalid && s1_axi_arready) begin hs1 = 1; gl.push_back(1); gl_cyc.push_back(cyc); end
      if (M_axi_rvalid && !M_axi_rready && slv_addr.size() > 0) stall_cnt++;
      if (M_axi_rvalid && M_axi_rready && slv_addr.size() > 0) begin
        if (M_axi_rlast) begin
          pop_cyc.push_back(cyc);
          slv_addr.pop_front();
          slv_len.pop_front();
          slv_beat = 0;
        end else begin
          slv_beat++;
        end
      end
      if (M_axi_arvalid && M_axi_arready) begin
        slv_addr.push_back(M_axi_araddr);
        slv_len.push_back(M_axi_arlen);
        mhs_cyc.push_back(cyc);
      end

      // model state update
      if (M_axi_rvalid && erdy && M_axi_rlast) m_q.pop_front();
      if (m_busy && M_axi_arready) begin
        m_q.push_back(m_own);
        m_busy = 0;
      end
      if (gnt) begin
        m_busy = 1; m_own = pick; m_last = pick;
        m_addr  = pick ? s1_axi_araddr  : s0_axi_araddr;
        m_len   = pick ? s1_axi_arlen   : s0_axi_arlen;
        m_size  = pick ? s1_axi_arsize  : s0_axi_arsize;
        m_burst = pick ? s1_axi_arburst : s0_axi_arburst;
        for (int i = 0; i <= int'(m_len); i++) begin
          if (pick) begin exp_d1.push_back(mkdata(m_addr, i)); exp_l1.push_back(i == int'(m_len)); end
          else      begin exp_d0.push_back(mkdata(m_addr, i)); exp_l0.push_back(i == int'(m_len)); end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b, bm, bp, r0, r1, sc, n;
    reset_n = 0;
    drive();
    repeat (3) step();
    reset_n = 1;
    step();

    // Tie fairness straight out of reset: s0 first, then alternate, AR every 2 cycles.
    b = gl.size(); bm = mhs_cyc.size();
    rq_addr0.push_back(32'h100);  rq_len0.push_back(8'd0);
    rq_addr0.push_back(32'h200);  rq_len0.push_back(8'd0);
    rq_addr1.push_back(32'h1100); rq_len1.push_back(8'd0);
    rq_addr1.push_back(32'h1200); rq_len1.push_back(8'd0);
    drain(200);
    chk("tie_grant_count", gl.size() - b, 4);
    if (gl.size() - b == 4 && mhs_cyc.size() - bm == 4) begin
      for (int i = 0; i < 4; i++) chk("tie_order", gl[b + i], i % 2);
      for (int i = 1; i < 4; i++) chk("tie_spacing", mhs_cyc[bm + i] - mhs_cyc[bm + i - 1], 2);
    end

    // Single request.
    r0 = rx0; r1 = rx1;
    rq_addr0.push_back(32'h1FC0); rq_len0.push_back(8'd3);
    step();
    #2;
    chk("single_s0_arready_c0", s0_axi_arready, 1);
    chk("single_s1_arready_c0", s1_axi_arready, 0);
    step();
    #2;
    chk("single_m_arvalid_c1", M_axi_arvalid, 1);
    chk("single_m_araddr_c1", M_axi_araddr, 32'h1FC0);
    chk("single_m_arlen_c1", M_axi_arlen, 8'd3);
    drain(200);
    chk("single_s0_beats", rx0 - r0, 4);
    chk("single_s1_beats", rx1 - r1, 0);

    // Outstanding limit with the slave stalling R.
    b = gl.size(); bm = mhs_cyc.size();
    slv_stall = 1;
    for (int i = 0; i < 4; i++) begin
      rq_addr0.push_back(32'h2000 + 32'(i * 64)); rq_len0.push_back(8'd1);
      rq_addr1.push_back(32'h3000 + 32'(i * 64)); rq_len1.push_back(8'd1);
    end
    repeat (16) step();
    chk("outst_m_handshakes", mhs_cyc.size() - bm, 4);
    chk("outst_grants", gl.size() - b, 4);
    bp = pop_cyc.size();
    slv_stall = 0;
    drain(400);
    chk("outst_total_grants", gl.size() - b, 8);
    if (gl.size() - b >= 5 && pop_cyc.size() > bp)
      chk("outst_regrant_after_pop", gl_cyc[b + 4] - pop_cyc[bp], 1);

    // Backpressure: s1 drops rready for 3 cycles mid-burst.
    r1 = rx1; sc = stall_cnt; n = 0;
    rq_addr1.push_back(32'h4000); rq_len1.push_back(8'd7);
    while (rx1 - r1 < 3 && n < 60) begin step(); n++; end
    rr1 = 0; s1_axi_rready = 0;
    repeat (3) step();
    rr1 = 1; s1_axi_rready = 1;
    drain(200);
    chk("bp_s1_beats", rx1 - r1, 8);
    chk("bp_stall_cycles", stall_cnt - sc, 3);

    // Interleaved return: s0 len7, s1 len1, s0 len0.
    b = gl.size(); r0 = rx0; r1 = rx1;
    rq_addr0.push_back(32'h5000); rq_len0.push_back(8'd7);
    rq_addr0.push_back(32'h6000); rq_len0.push_back(8'd0);
    rq_addr1.push_back(32'h7000); rq_len1.push_back(8'd1);
    drain(300);
    chk("intl_grant_count", gl.size() - b, 3);
    if (gl.size() - b == 3) begin
      chk("intl_order0", gl[b], 0);
      chk("intl_order1", gl[b + 1], 1);
      chk("intl_order2", gl[b + 2], 0);
    end
    chk("intl_s0_beats", rx0 - r0, 9);
    chk("intl_s1_beats", rx1 - r1, 2);

    // Reset during beat 2 of an 8-beat burst.
    r0 = rx0; n = 0;
    rq_addr0.push_back(32'h8000); rq_len0.push_back(8'd7);
    while (rx0 - r0 < 1 && n < 60) begin step(); n++; end
    #2;
    reset_n = 0;
    #1;
    chk("rstmid_m_arvalid", M_axi_arvalid, 0);
    chk("rstmid_m_rready", M_axi_rready, 0);
    chk("rstmid_s0_rvalid", s0_axi_rvalid, 0);
    chk("rstmid_s1_rvalid", s1_axi_rvalid, 0);
    chk("rstmid_arready", {s0_axi_arready, s1_axi_arready}, 0);
    chk("rstmid_m_araddr", M_axi_araddr, 0);
    rq_addr0.delete(); rq_len0.delete(); rq_addr1.delete(); rq_len1.delete();
    hs0 = 0; hs1 = 0;
    slv_addr.delete(); slv_len.delete(); slv_beat = 0;
    exp_d0.delete(); exp_l0.delete(); exp_d1.delete(); exp_l1.delete();
    repeat (2) step();
    reset_n = 1;
    stray = 1;
    step();
    #2;
    chk("stray_m_rready", M_axi_rready, 0);
    chk("stray_s0_rvalid", s0_axi_rvalid, 0);
    step();
    stray = 0;
    b = gl.size(); r1 = rx1;
    rq_addr1.push_back(32'h9000); rq_len1.push_back(8'd2);
    drain(200);
    chk("post_rst_grant_count", gl.size() - b, 1);
    if (gl.size() - b == 1) chk("post_rst_grant_s1", gl[b], 1);
    chk("post_rst_s1_beats", rx1 - r1, 3);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter_2to1.md
# axi_rd_arbiter_2to1

Shares one AXI4 read channel (address + data) between two read requesters, e.g. the input-layer 3x3 window fetcher and a kernel/weight loader, in front of the single block-RAM/DDR3 AXI slave. Requests are granted round-robin and forwarded one address phase at a time. Read data is routed back to the owning requester using an in-order owner FIFO. The write channel is not touched; it stays wired directly between its master and the slave.

## Interface
Parameters:
- C_S_AXI_ADDR_WIDTH, 32, address width
- C_S_AXI_DATA_WIDTH, 128, read data width
- MAX_OUTSTANDING, 4, owner-FIFO depth (power of 2, >=2) = max bursts in flight

Ports (x = 0,1):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset; single clock domain
- sx_axi_araddr  in  ADDR  requester x burst address
- sx_axi_arlen  in  8  burst length-1
- sx_axi_arsize  in  3  beat size
- sx_axi_arburst  in  2  burst type
- sx_axi_arvalid  in  1  request valid
- sx_axi_arready  out  1  request accepted
- sx_axi_rdata  out  DATA  read data to x
- sx_axi_rresp  out  2  response to x
- sx_axi_rlast  out  1  last beat to x
- sx_axi_rvalid  out  1  beat valid to x
- sx_axi_rready  in  1  x accepts beat
- M_axi_arid  out  1  constant 0
- M_axi_araddr / M_axi_arlen / M_axi_arsize / M_axi_arburst  out  ADDR/8/3/2  registered forwarded request
- M_axi_arlock out 1 = 0; M_axi_arcache out 4 = 4'b0011; M_axi_arprot out 3 = 0; M_axi_arqos out 4 = 0
- M_axi_arvalid  out  1  address valid
- M_axi_arready  in  1  slave accepts address
- M_axi_rid  in  1  ignored (single ID, in-order)
- M_axi_rdata / M_axi_rresp / M_axi_rlast / M_axi_rvalid  in  DATA/2/1/1  slave read data
- M_axi_rready  out  1  routed ready

## Operation
- AR FSM, states IDLE and ADDR.
- IDLE: eligible when owner-FIFO count < MAX_OUTSTANDING. Winner = requester with arvalid. If both are valid, the winner is the one not granted last (rr_last, reset 1, so s0 wins the first tie).
  - Winner's sx_axi_arready is combinationally high in IDLE while eligible and its arvalid is high.
  - On that edge, capture addr/len/size/burst into output registers, record owner, set rr_last = owner, and go to ADDR.
- ADDR: M_axi_arvalid = 1 with registered fields held stable. On M_axi_arvalid & M_axi_arready, push owner into the FIFO, drop arvalid, and return to IDLE.
- No sx_axi_arready is asserted while in ADDR.
- R routing:
  - head = FIFO front. sx_axi_rvalid = M_axi_rvalid & !empty & (head == x).
  - M_axi_rready = !empty & s[head]_axi_rready.
  - rdata/rresp/rlast are passed combinationally to both requesters; only rvalid is gated.
  - Pop on M_axi_rvalid & M_axi_rready & M_axi_rlast.
- FIFO: push and pop in the same cycle leave count unchanged. Push never happens when full, because grant requires count < MAX_OUTSTANDING and pop only lowers count. Pointers wrap modulo MAX_OUTSTANDING; count width is log2(MAX_OUTSTANDING)+1.
- FIFO empty: M_axi_rready = 0; stray slave data is never consumed or forwarded.
- Reset (async assert, any state, including mid-burst):
  - FSM returns to IDLE, FIFO is emptied, rr_last = 1.
  - M_axi_arvalid, M_axi_rready, all sx_axi_arready and sx_axi_rvalid = 0; M_axi_ar* registers = 0.
  - In-flight bursts are abandoned.

## Timing
- AR latency: requester handshake at edge N; M_axi_arvalid high from cycle N+1; with arready=1 the slave handshake happens at edge N+1.
- Peak AR throughput: one grant every 2 cycles.
- R path: zero-cycle combinational pass-through, no added latency. Throughput 1 beat/cycle when the owner holds rready.
- Requester x must hold arvalid and its fields until sx_axi_arready; a held request that loses a tie wins the next IDLE grant.
- Beats arrive in AR issue order; ownership switches only after rlast.

## Test plan
- Single request: s0 arvalid, araddr=0x1FC0, arlen=3 → s0_arready at cycle 0, M_axi_arvalid at cycle 1 with araddr 0x1FC0 and arlen 3; 4 beats reach s0 only, s1_rvalid stays 0, FIFO count returns to 0 after rlast.
- Tie fairness: s0 and s1 both hold arvalid continuously with arlen=0 → grant order s0,s1,s0,s1; one M_axi_arvalid every 2 cycles.
- Outstanding limit: slave stalls R and both requesters flood requests → exactly 4 AR handshakes, then no sx_axi_arready until the first rlast. The 5th AR is issued the cycle after that pop.
- Backpressure: owner s1 drops rready for 3 cycles mid-burst → M_axi_rready low those cycles; no beat lost or duplicated; data order intact.
- Interleaved return: issue s0 (len 7), s1 (len 1), s0 (len 0) → beats 8/2/1 routed respectively in that order; simultaneous push+pop keeps count correct.
- Reset mid-burst: assert reset_n=0 during beat 2 of 8 → all valids/readys 0 immediately. After release, a new s1 request is granted first (rr_last=1 → tie to s0, single request to s1) and the FIFO starts empty.
